// File: rtl/sm_seg_scan_ctrl.sv
// sm_seg_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit seven-segment display.
//   A free-running prescaler sets the digit period (2^PRESCALE_W clocks);
//   each digit slot opens with BLANK_CYCLES of all-anodes-off to avoid
//   ghosting, then the digit is lit for a 16-level PWM duty. New display
//   data is held pending and applied only at the frame boundary.
//
// Ports:
//   clk, rst_n   system clock (rising edge), asynchronous active-low reset
//   data_i       four hex nibbles, digit k = data_i[4k+3:4k]
//   data_we      single-cycle load request for data_i / dp_i
//   dp_i         decimal point per digit, active-high
//   lz_suppress  leading-zero suppression enable (live)
//   brightness   PWM duty level 0..15 (live)
//   gpio_out     [15:12]=0, [11:8]=anode one-hot, [7]=dp, [6:0]=seg g..a
//   pending_o    a load is waiting for the frame boundary
//   frame_o      one-cycle pulse in the cycle after each frame boundary
module sm_seg_scan_ctrl #(
    parameter int PRESCALE_W     = 10,
    parameter int BLANK_CYCLES   = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] data_i,
    input  logic        data_we,
    input  logic [3:0]  dp_i,
    input  logic        lz_suppress,
    input  logic [3:0]  brightness,
    output logic [15:0] gpio_out,
    output logic        pending_o,
    output logic        frame_o
);

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} digit_t;

    localparam logic [PRESCALE_W-1:0] CNT_MAX   = '1;
    localparam logic [PRESCALE_W-1:0] BLANK_CNT = PRESCALE_W'(BLANK_CYCLES);
    localparam logic [7:0]            SEG_IDLE  = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [15:0]           GPIO_IDLE = {8'h00, SEG_IDLE};

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    logic [PRESCALE_W-1:0] cnt;
    digit_t                idx;
    digit_t                idx_next;
    logic [1:0]            sel;
    logic [15:0]           shadow_data;
    logic [3:0]            shadow_dp;
    logic [15:0]           pend_data;
    logic [3:0]            pend_dp;
    logic                  pending;
    logic                  cnt_wrap;
    logic                  boundary;
    logic [3:0]            slot;
    logic [3:0]            nibble;
    logic [3:0]            suppressed;
    logic                  lit;
    logic [15:0]           gpio_next;

    assign cnt_wrap  = (cnt == CNT_MAX);
    assign boundary  = cnt_wrap && (idx == DIG3);
    assign slot      = cnt[PRESCALE_W-1 -: 4];
    assign sel       = idx;
    assign pending_o = pending;

    // Digit sequencer: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= DIG0;
        end else begin
            cnt <= cnt + 1'b1;
            idx <= idx_next;
        end
    end

    // Digit sequencer: advance on prescaler wrap
    always_comb begin
        idx_next = idx;
        if (cnt_wrap) begin
            case (idx)
                DIG0:    idx_next = DIG1;
                DIG1:    idx_next = DIG2;
                DIG2:    idx_next = DIG3;
                default: idx_next = DIG0;
            endcase
        end
    end

    // Digit k is blank when it and every more-significant nibble are zero
    always_comb begin
        suppressed = '0;
        if (lz_suppress) begin
            suppressed[3] = (shadow_data[15:12] == 4'h0);
            suppressed[2] = (shadow_data[15:8]  == 8'h00);
            suppressed[1] = (shadow_data[15:4]  == 12'h000);
        end
    end

    always_comb begin
        nibble    = shadow_data[{sel, 2'b00} +: 4];
        lit       = (cnt >= BLANK_CNT) && (slot <= brightness) && !suppressed[sel];
        gpio_next = GPIO_IDLE;
        if (lit) begin
            gpio_next[11:8] = 4'b0001 << sel;
            gpio_next[7]    = shadow_dp[sel] ^ SEG_ACTIVE_LOW;
            gpio_next[6:0]  = seg_decode(nibble) ^ {7{SEG_ACTIVE_LOW}};
        end
    end

    // Load handshake: a write landing on the boundary goes straight to the
    // shadow, otherwise it parks in the pending registers until the boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_data <= '0;
            shadow_dp   <= '0;
            pend_data   <= '0;
            pend_dp     <= '0;
            pending     <= 1'b0;
            frame_o     <= 1'b0;
            gpio_out    <= GPIO_IDLE;
        end else begin
            if (boundary && data_we) begin
                shadow_data <= data_i;
                shadow_dp   <= dp_i;
                pending     <= 1'b0;
            end else begin
                if (boundary && pending) begin
                    shadow_data <= pend_data;
                    shadow_dp   <= pend_dp;
                    pending     <= 1'b0;
                end
                if (data_we) begin
                    pend_data <= data_i;
                    pend_dp   <= dp_i;
                    pending   <= 1'b1;
                end
            end
            frame_o  <= boundary;
            gpio_out <= gpio_next;
        end
    end

endmodule

// File: tb/tb_sm_seg_scan_ctrl.sv
// Testbench for sm_seg_scan_ctrl with PRESCALE_W=6 (64-clock slots, 256-clock
// frames) and BLANK_CYCLES=2. Two instances share stimulus: one active-high,
// one with SEG_ACTIVE_LOW=1. Expected per-digit display words are constants;
// the bench tracks clocks since reset release to know the scan position.
module tb_sm_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data_i = '0;
    logic        data_we = 1'b0;
    logic [3:0]  dp_i = '0;
    logic        lz_suppress = 1'b0;
    logic [3:0]  brightness = 4'd15;
    logic [15:0] gpio_out, gpio_out_n;
    logic        pending_o, pending_n;
    logic        frame_o, frame_n;

    sm_seg_scan_ctrl #(
        .PRESCALE_W(6), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .data_we(data_we),
        .dp_i(dp_i), .lz_suppress(lz_suppress), .brightness(brightness),
        .gpio_out(gpio_out), .pending_o(pending_o), .frame_o(frame_o)
    );

    sm_seg_scan_ctrl #(
        .PRESCALE_W(6), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1)
    ) dut_n (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .data_we(data_we),
        .dp_i(dp_i), .lz_suppress(lz_suppress), .brightness(brightness),
        .gpio_out(gpio_out_n), .pending_o(pending_n), .frame_o(frame_n)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          fails = 0;
    int          cyc = 0;          // rising edges since reset release
    logic [15:0] disp[4];          // expected lit word per digit
    logic [15:0] nxt[4];           // words that take effect at next frame
    bit          upd = 1'b0;
    logic [15:0] exp_q[$];

    task automatic set_zero_disp();
        disp = '{16'h013F, 16'h023F, 16'h043F, 16'h083F};
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    // Scoreboard: push the word expected for the current scan position,
    // clock once, then pop and compare against the registered output.
    task automatic run(input int n);
        int          c;
        int          d;
        logic [15:0] e;
        logic        ef;
        for (int i = 0; i < n; i++) begin
            if ((cyc % 256 == 0) && upd) begin
                disp = nxt;
                upd  = 1'b0;
            end
            c = cyc % 64;
            d = (cyc / 64) % 4;
            if (c >= 2 && (c / 4) <= int'(brightness)) e = disp[d];
            else e = 16'h0000;
            exp_q.push_back(e);
            tick();
            e = exp_q.pop_front();
            checks++;
            if (gpio_out !== e) begin
                fails++;
                $display("FAIL scan cyc=%0d gpio_out got=%h exp=%h", cyc, gpio_out, e);
            end
            ef = (cyc % 256 == 0) && (cyc != 0);
            checks++;
            if (frame_o !== ef) begin
                fails++;
                $display("FAIL frame_o cyc=%0d got=%b exp=%b", cyc, frame_o, ef);
            end
        end
    endtask

    task automatic goto(input int phase);
        while (cyc % 256 != phase) run(1);
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p,
                        input logic [15:0] n0, input logic [15:0] n1,
                        input logic [15:0] n2, input logic [15:0] n3);
        data_i  = d;
        dp_i    = p;
        data_we = 1'b1;
        nxt     = '{n0, n1, n2, n3};
        upd     = 1'b1;
        run(1);
        data_we = 1'b0;
    endtask

    task automatic check_pending(input string name, input logic exp);
        checks++;
        if (pending_o !== exp) begin
            fails++;
            $display("FAIL %s pending_o got=%b exp=%b", name, pending_o, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (gpio_out !== 16'h0000 || pending_o !== 1'b0 || frame_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold got=%h/%b/%b exp=0000/0/0", gpio_out, pending_o, frame_o);
        end
        checks++;
        if (gpio_out_n !== 16'h00FF || pending_n !== 1'b0 || frame_n !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold_n got=%h/%b/%b exp=00ff/0/0", gpio_out_n, pending_n, frame_n);
        end
        rst_n = 1'b1;
        cyc   = 0;
        upd   = 1'b0;
        set_zero_disp();
        checks++;
        if (gpio_out !== 16'h0000) begin
            fails++;
            $display("FAIL reset_release gpio_out got=%h exp=0000", gpio_out);
        end
        run(4);   // cycle 3 carries the first lit word 013F
    endtask

    task automatic test_scan_order();
        load(16'h1234, 4'b0000, 16'h0166, 16'h024F, 16'h045B, 16'h0806);
        check_pending("scan_load", 1'b1);
        goto(0);
        check_pending("scan_boundary", 1'b0);
        run(256);
    endtask

    task automatic test_tear_free();
        goto(96);
        load(16'hABCD, 4'b0000, 16'h015E, 16'h0239, 16'h047C, 16'h0877);
        check_pending("tear_load", 1'b1);
        goto(0);
        check_pending("tear_boundary", 1'b0);
        run(256);
    endtask

    task automatic test_back_to_back();
        goto(255);
        load(16'h5678, 4'b0000, 16'h017F, 16'h0207, 16'h047D, 16'h086D);
        check_pending("collision_edge", 1'b0);
        for (int i = 0; i < 4; i++) begin
            run(1);
            check_pending("collision_after", 1'b0);
        end
        run(256);
        goto(10);
        load(16'h1111, 4'b0000, 16'h0106, 16'h0206, 16'h0406, 16'h0806);
        goto(20);
        load(16'h9ABC, 4'b0000, 16'h0139, 16'h027C, 16'h0477, 16'h086F);
        check_pending("overwrite", 1'b1);
        goto(0);
        check_pending("overwrite_boundary", 1'b0);
        run(256);
    endtask

    task automatic test_suppress_brightness();
        lz_suppress = 1'b1;
        goto(50);
        load(16'h0050, 4'b1000, 16'h013F, 16'h026D, 16'h0000, 16'h0000);
        goto(0);
        run(256);
        brightness = 4'd0;
        run(256);
        brightness  = 4'd15;
        lz_suppress = 1'b0;
        disp = '{16'h013F, 16'h026D, 16'h043F, 16'h08BF};
        run(256);
    endtask

    task automatic test_active_low();
        goto(100);
        load(16'h0008, 4'b0001, 16'h01FF, 16'h023F, 16'h043F, 16'h083F);
        goto(0);
        run(1);
        checks++;
        if (gpio_out_n !== 16'h00FF) begin
            fails++;
            $display("FAIL active_low_blank got=%h exp=00ff", gpio_out_n);
        end
        run(2);
        checks++;
        if (gpio_out_n !== 16'h0100) begin
            fails++;
            $display("FAIL active_low_digit0 got=%h exp=0100", gpio_out_n);
        end
        goto(67);
        checks++;
        if (gpio_out_n !== 16'h02C0) begin
            fails++;
            $display("FAIL active_low_digit1 got=%h exp=02c0", gpio_out_n);
        end
        goto(0);
    endtask

    task automatic test_reset_mid();
        goto(70);
        load(16'hFFFF, 4'hF, 16'h01F1, 16'h02F1, 16'h04F1, 16'h08F1);
        check_pending("mid_load", 1'b1);
        run(10);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gpio_out !== 16'h0000 || pending_o !== 1'b0 || frame_o !== 1'b0) begin
            fails++;
            $display("FAIL async_reset got=%h/%b/%b exp=0000/0/0", gpio_out, pending_o, frame_o);
        end
        checks++;
        if (gpio_out_n !== 16'h00FF || pending_n !== 1'b0) begin
            fails++;
            $display("FAIL async_reset_n got=%h/%b exp=00ff/0", gpio_out_n, pending_n);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        upd   = 1'b0;
        set_zero_disp();
        check_pending("mid_release", 1'b0);
        run(300);   // the discarded load must never appear
        check_pending("mid_lost", 1'b0);
    endtask

    initial begin
        set_zero_disp();
        nxt = disp;
        @(negedge clk);
        test_reset();
        test_scan_order();
        test_tear_free();
        test_back_to_back();
        test_suppress_brightness();
        test_active_low();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
